avl_packetizer: RTL
===================

AVL_PACKETIZER -- requirements
Module: avl_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of sample and stream words.
REQ-002 SHALL have parameter PAYLOAD_LEN, default 64, number of payload samples per packet (legal range 2..65535).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, sample buffer depth (power of 2, at least 4).
REQ-004 SHALL have parameter SENSOR_TYPE, default 16'h0001, value of header word 0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit: packet generation enabled.
REQ-008 SHALL have port sample_valid, input, 1 bit: raw ADC sample strobe; the source cannot stall.
REQ-009 SHALL have port sample_data, input, DATA_WIDTH bits: raw ADC sample.
REQ-010 SHALL have port data_output_ready, input, 1 bit: Avalon-ST sink ready, readyLatency 0.
REQ-011 SHALL have ports data_output_valid, data_output_startofpacket and data_output_endofpacket, each output, 1 bit: Avalon-ST source controls.
REQ-012 SHALL have port data_output_data, output, DATA_WIDTH bits: Avalon-ST source data.
REQ-013 SHALL have port scan_count, output, 32 bits: number of packets completed since reset.

Function
REQ-014 SHALL frame each packet as word 0 = SENSOR_TYPE with SOP, word 1 = scan_count[31:16], word 2 = scan_count[15:0], then PAYLOAD_LEN samples, then one trailer error word with EOP.
REQ-015 SHALL push a sample into the FIFO in the cycle sample_valid=1, enable=1 and the FIFO is not full.
REQ-016 SHALL discard the sample, without writing the FIFO, when sample_valid=1 and the FIFO is full, and SHALL set the sticky overflow flag.
REQ-017 SHALL discard samples while enable=0, and SHALL then also flush the FIFO.
REQ-018 SHALL treat a push and a pop in the same cycle on a full FIFO as a legal push (no overflow).
REQ-019 SHALL use FSM states IDLE, HDR_TYPE, HDR_CNT_HI, HDR_CNT_LO, PAYLOAD and TRAILER.
REQ-020 SHALL go IDLE -> HDR_TYPE when enable=1 and the FIFO is non-empty.
REQ-021 SHALL advance each header state and TRAILER only on an accepted beat (valid=1 and ready=1).
REQ-022 SHALL go TRAILER -> IDLE on the accepted beat.
REQ-023 SHALL, in PAYLOAD, present the FIFO head with valid=1 only when the FIFO is non-empty, and pop the FIFO on each accepted beat.
REQ-024 SHALL go PAYLOAD -> TRAILER after the PAYLOAD_LEN-th accepted sample.
REQ-025 SHALL, if enable falls in any header state or in PAYLOAD, finish the current beat and then go directly to TRAILER with the truncated flag set; no further samples are sent.
REQ-026 SHALL encode the trailer word as bit0 = overflow, bit1 = truncated, bits[DATA_WIDTH-1:2] = 0.
REQ-027 SHALL clear the overflow and truncated flags when the trailer is accepted; an overflow occurring in that same cycle SHALL remain set for the next packet.
REQ-028 SHALL increment scan_count by 1 on trailer acceptance, wrapping 32'hFFFFFFFF -> 0; header words SHALL carry the count latched at packet start.
REQ-029 SHALL hold data, SOP, EOP and valid stable while valid=1 and ready=0; valid SHALL never be withdrawn before acceptance except by reset.
REQ-030 SHALL register all outputs, with no combinational path from data_output_ready to any output.
REQ-031 SHALL allow a sample written to the empty FIFO to appear on data_output_data no earlier than 2 cycles later.
REQ-032 SHALL support back-to-back packets: IDLE lasts one cycle when the start condition already holds.

Reset
REQ-033 SHALL, with reset_n=0 at a clock edge, set FSM=IDLE, empty the FIFO, clear both flags and scan_count, and drive all stream outputs to 0.
REQ-034 SHALL abandon a partially sent packet on reset mid-packet, with no EOP emitted.

Structure
REQ-035 SHALL place the state typedef (onehot), trailer bit positions and header word indices in package avl_pkt_pkg.
REQ-036 SHALL implement the FIFO as sub-module sync_fifo, parameterised by width and depth, with full, empty and count outputs and a synchronous active-low reset.

Verification
REQ-037 SHALL verify nominal framing: PAYLOAD_LEN=4, ready=1, samples 1..8 continuous -> two packets [0001,0000,0000,1,2,3,4,0000] and [0001,0000,0001,5,6,7,8,0000], with scan_count=2.
REQ-038 SHALL verify backpressure: ready toggles 1/0 every cycle -> each word is held across stall cycles and the sequence is identical to REQ-037.
REQ-039 SHALL verify overflow: FIFO_DEPTH=4, ready=0 for 10 samples -> 4 samples are kept, 6 are dropped, and the trailer equals 0001.
REQ-040 SHALL verify truncation: enable drops after payload sample 2 of 4 -> the packet ends after 2 samples with trailer 0002, and the FIFO is flushed.
REQ-041 SHALL verify wrap: scan_count forced to FFFFFFFF -> header words FFFF and FFFF are sent, then scan_count becomes 0.
REQ-042 SHALL verify reset mid-payload: reset_n=0 for 1 cycle -> outputs are 0 the next cycle, and the next packet carries header count 0000,0000.

Source files
------------

// File: rtl/avl_pkt_pkg.sv
// Shared definitions for the Avalon-ST sensor packetizer: FSM encoding,
// header word indices and trailer flag layout.
package avl_pkt_pkg;

    typedef enum logic [5:0] {
        IDLE       = 6'b000001,
        HDR_TYPE   = 6'b000010,
        HDR_CNT_HI = 6'b000100,
        HDR_CNT_LO = 6'b001000,
        PAYLOAD    = 6'b010000,
        TRAILER    = 6'b100000
    } pkt_state_e;

    localparam int HDR_IDX_TYPE   = 0;
    localparam int HDR_IDX_CNT_HI = 1;
    localparam int HDR_IDX_CNT_LO = 2;

    localparam int TRL_OVF_BIT   = 0;
    localparam int TRL_TRUNC_BIT = 1;

    function automatic logic [1:0] trailer_flags(input logic ovf, input logic trunc);
        logic [1:0] f;
        f                = '0;
        f[TRL_OVF_BIT]   = ovf;
        f[TRL_TRUNC_BIT] = trunc;
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head and second-entry peek, flush and
// occupancy count. DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         next_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_wr;
    logic             do_rd;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_q + AW'(1)];

    // A write into a full FIFO is legal when a read frees a slot in the same cycle.
    assign do_rd   = rd_en_i & ~empty_o & ~flush_i;
    assign do_wr   = wr_en_i & ~flush_i & (~full_o | do_rd);
    assign count_d = count_q + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);

    always_ff @(posedge clk) begin
        if (!reset_n_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/avl_packetizer.sv
// Buffers raw ADC samples and frames them into Avalon-ST packets:
// type, count hi, count lo, PAYLOAD_LEN samples, then an error trailer.
module avl_packetizer
    import avl_pkt_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    PAYLOAD_LEN = 64,
    parameter int                    FIFO_DEPTH  = 16,
    parameter logic [DATA_WIDTH-1:0] SENSOR_TYPE = DATA_WIDTH'(16'h0001)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  data_output_ready,
    output logic                  data_output_valid,
    output logic                  data_output_startofpacket,
    output logic                  data_output_endofpacket,
    output logic [DATA_WIDTH-1:0] data_output_data,
    output logic [31:0]           scan_count
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] LAST_BEAT = 16'(PAYLOAD_LEN - 1);

    pkt_state_e            state_q;
    logic                  valid_q;
    logic                  sop_q;
    logic                  eop_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ovf_q;
    logic                  trunc_q;
    logic [31:0]           scan_count_q;
    logic [31:0]           cnt_latch_q;
    logic [15:0]           beat_cnt_q;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic [DATA_WIDTH-1:0] fifo_next;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;

    logic                  accept;
    logic                  pop;
    logic                  stop;
    logic                  in_pkt;
    logic                  ovf_evt;
    logic                  trunc_now;
    logic [DATA_WIDTH-1:0] pl_word;
    logic                  pl_avail;
    logic [DATA_WIDTH-1:0] trl_word_d;

    function automatic logic [DATA_WIDTH-1:0] hdr_word(input int idx, input logic [31:0] cnt);
        logic [DATA_WIDTH-1:0] w;
        case (idx)
            HDR_IDX_TYPE:   w = SENSOR_TYPE;
            HDR_IDX_CNT_HI: w = DATA_WIDTH'(cnt[31:16]);
            HDR_IDX_CNT_LO: w = DATA_WIDTH'(cnt[15:0]);
            default:        w = '0;
        endcase
        return w;
    endfunction

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n_i (reset_n),
        .flush_i   (~enable),
        .wr_en_i   (sample_valid & enable),
        .wr_data_i (sample_data),
        .rd_en_i   (pop),
        .head_o    (fifo_head),
        .next_o    (fifo_next),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign accept    = valid_q & data_output_ready;
    assign pop       = accept & (state_q == PAYLOAD);
    assign stop      = trunc_q | ~enable;
    assign in_pkt    = state_q inside {HDR_TYPE, HDR_CNT_HI, HDR_CNT_LO, PAYLOAD};
    assign ovf_evt   = sample_valid & enable & fifo_full & ~pop;
    assign trunc_now = trunc_q | (in_pkt & ~enable);

    // The sample in the output register is still the FIFO head until it is
    // accepted, so on an accepted beat the following word is the second entry.
    assign pl_word  = pop ? fifo_next : fifo_head;
    assign pl_avail = pop ? (fifo_count > CW'(1)) : ~fifo_empty;

    always_comb begin
        trl_word_d      = '0;
        trl_word_d[1:0] = trailer_flags(ovf_q | ovf_evt, trunc_now);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            data_q       <= '0;
            ovf_q        <= 1'b0;
            trunc_q      <= 1'b0;
            scan_count_q <= '0;
            cnt_latch_q  <= '0;
            beat_cnt_q   <= '0;
        end else begin
            ovf_q <= ovf_q | ovf_evt;
            if (in_pkt && !enable) begin
                trunc_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        state_q     <= HDR_TYPE;
                        valid_q     <= 1'b1;
                        sop_q       <= 1'b1;
                        data_q      <= hdr_word(HDR_IDX_TYPE, scan_count_q);
                        cnt_latch_q <= scan_count_q;
                    end
                end
                HDR_TYPE: begin
                    if (accept) begin
                        sop_q <= 1'b0;
                        if (stop) begin
                            state_q <= TRAILER;
                            eop_q   <= 1'b1;
                            data_q  <= trl_word_d;
                        end else begin
                            state_q <= HDR_CNT_HI;
                            data_q  <= hdr_word(HDR_IDX_CNT_HI, cnt_latch_q);
                        end
                    end
                end
                HDR_CNT_HI: begin
                    if (accept) begin
                        if (stop) begin
                            state_q <= TRAILER;
                            eop_q   <= 1'b1;
                            data_q  <= trl_word_d;
                        end else begin
                            state_q <= HDR_CNT_LO;
                            data_q  <= hdr_word(HDR_IDX_CNT_LO, cnt_latch_q);
                        end
                    end
                end
                HDR_CNT_LO: begin
                    if (accept) begin
                        if (stop) begin
                            state_q <= TRAILER;
                            eop_q   <= 1'b1;
                            data_q  <= trl_word_d;
                        end else begin
                            state_q    <= PAYLOAD;
                            beat_cnt_q <= '0;
                            valid_q    <= pl_avail;
                            data_q     <= pl_word;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        if (stop || beat_cnt_q == LAST_BEAT) begin
                            state_q <= TRAILER;
                            valid_q <= 1'b1;
                            eop_q   <= 1'b1;
                            data_q  <= trl_word_d;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 16'd1;
                            valid_q    <= pl_avail;
                            data_q     <= pl_word;
                        end
                    end else if (!valid_q) begin
                        if (stop) begin
                            state_q <= TRAILER;
                            valid_q <= 1'b1;
                            eop_q   <= 1'b1;
                            data_q  <= trl_word_d;
                        end else if (pl_avail) begin
                            valid_q <= 1'b1;
                            data_q  <= pl_word;
                        end
                    end
                end
                TRAILER: begin
                    if (accept) begin
                        state_q      <= IDLE;
                        valid_q      <= 1'b0;
                        eop_q        <= 1'b0;
                        data_q       <= '0;
                        scan_count_q <= scan_count_q + 32'd1;
                        trunc_q      <= 1'b0;
                        // Keep an overflow the frozen trailer word did not report.
                        ovf_q        <= ovf_evt | (ovf_q & ~data_q[TRL_OVF_BIT]);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    sop_q   <= 1'b0;
                    eop_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_output_valid         = valid_q;
    assign data_output_startofpacket = sop_q;
    assign data_output_endofpacket   = eop_q;
    assign data_output_data          = data_q;
    assign scan_count                = scan_count_q;

endmodule
